// File: rtl/rv64_pkg.sv
// Shared RV64 memory-stage definitions: store funct3 encodings, AXI response
// codes and the store unit state type.
package rv64_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_B,
    ST_FAULT,
    ST_RESP
  } store_state_e;

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment for a 64-bit bus: byte strobes, shifted data
// and the misaligned/illegal-width flag. Shared with the load path.
module store_align
  import rv64_pkg::*;
#(
  parameter int DLEN = 64,
  parameter int SLEN = DLEN / 8
) (
  input  logic [2:0]      width,
  input  logic [2:0]      lane,
  input  logic [DLEN-1:0] data,
  output logic [SLEN-1:0] wstrb,
  output logic [DLEN-1:0] wdata,
  output logic            fault
);

  logic [3:0] nbytes;
  logic [3:0] lane_ext;

  assign nbytes   = 4'd1 << width[1:0];
  assign lane_ext = {1'b0, lane};
  assign wdata    = data << {lane, 3'b000};

  // A byte is enabled when it falls inside [lane, lane + size); bytes past
  // the top of the bus drop off, matching mask << lane truncated to SLEN.
  genvar gi;
  generate
    for (gi = 0; gi < SLEN; gi++) begin : g_strb
      assign wstrb[gi] = (4'(gi) >= lane_ext) && (4'(gi) < lane_ext + nbytes);
    end
  endgenerate

  always_comb begin
    fault = 1'b0;
    case (width)
      F3_SB:   fault = 1'b0;
      F3_SH:   fault = lane[0];
      F3_SW:   fault = |lane[1:0];
      F3_SD:   fault = |lane;
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Datapath store request to a single AXI-Lite write (AW/W/B), with
// completion, misalignment and bus-error reporting back to the datapath.
module store_unit
  import rv64_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ALEN = XLEN,
  parameter int DLEN = XLEN,
  parameter int SLEN = DLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tvalid,
  output logic            o_tready,
  input  logic [XLEN-1:0] i_base_addr,
  input  logic [XLEN-1:0] i_offset,
  input  logic [2:0]      i_width,
  input  logic [XLEN-1:0] i_data,
  output logic            o_awvalid,
  input  logic            i_awready,
  output logic [ALEN-1:0] o_awaddr,
  output logic [2:0]      o_awprot,
  output logic            o_wvalid,
  input  logic            i_wready,
  output logic [DLEN-1:0] o_wdata,
  output logic [SLEN-1:0] o_wstrb,
  input  logic            i_bvalid,
  output logic            o_bready,
  input  logic [1:0]      i_bresp,
  output logic            o_done,
  output logic            o_misaligned,
  output logic            o_bus_err
);

  store_state_e    state_reg;
  logic            awvalid_reg;
  logic            wvalid_reg;
  logic            bready_reg;
  logic            done_reg;
  logic            misaligned_reg;
  logic            bus_err_reg;
  logic [ALEN-1:0] awaddr_reg;
  logic [DLEN-1:0] wdata_reg;
  logic [SLEN-1:0] wstrb_reg;

  logic [XLEN-1:0] addr_next;
  logic [SLEN-1:0] wstrb_next;
  logic [DLEN-1:0] wdata_next;
  logic            fault_next;
  logic            aw_fire;
  logic            w_fire;
  logic            aw_clear;
  logic            w_clear;

  assign addr_next = i_base_addr + i_offset;

  store_align #(
    .DLEN (DLEN),
    .SLEN (SLEN)
  ) u_align (
    .width (i_width),
    .lane  (addr_next[2:0]),
    .data  (i_data),
    .wstrb (wstrb_next),
    .wdata (wdata_next),
    .fault (fault_next)
  );

  assign aw_fire  = awvalid_reg && i_awready;
  assign w_fire   = wvalid_reg && i_wready;
  // A channel is finished if it handshakes now or already did earlier.
  assign aw_clear = aw_fire || !awvalid_reg;
  assign w_clear  = w_fire || !wvalid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      done_reg       <= 1'b0;
      misaligned_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_tvalid) begin
            if (fault_next) begin
              state_reg      <= ST_FAULT;
              done_reg       <= 1'b1;
              misaligned_reg <= 1'b1;
            end else begin
              state_reg   <= ST_SEND;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              awaddr_reg  <= addr_next[ALEN-1:0];
              wdata_reg   <= wdata_next;
              wstrb_reg   <= wstrb_next;
            end
          end
        end
        ST_SEND: begin
          if (aw_fire) awvalid_reg <= 1'b0;
          if (w_fire)  wvalid_reg  <= 1'b0;
          if (aw_clear && w_clear) begin
            state_reg  <= ST_WAIT_B;
            bready_reg <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (i_bvalid) begin
            state_reg   <= ST_RESP;
            bready_reg  <= 1'b0;
            done_reg    <= 1'b1;
            bus_err_reg <= (i_bresp == AXI_RESP_SLVERR) || (i_bresp == AXI_RESP_DECERR);
          end
        end
        ST_FAULT: begin
          state_reg      <= ST_IDLE;
          done_reg       <= 1'b0;
          misaligned_reg <= 1'b0;
        end
        ST_RESP: begin
          state_reg   <= ST_IDLE;
          done_reg    <= 1'b0;
          bus_err_reg <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_tready     = (state_reg == ST_IDLE);
  assign o_awvalid    = awvalid_reg;
  assign o_awaddr     = awaddr_reg;
  assign o_awprot     = 3'b000;
  assign o_wvalid     = wvalid_reg;
  assign o_wdata      = wdata_reg;
  assign o_wstrb      = wstrb_reg;
  assign o_bready     = bready_reg;
  assign o_done       = done_reg;
  assign o_misaligned = misaligned_reg;
  assign o_bus_err    = bus_err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: aligned stores, misaligned/illegal requests,
// split AW/W handshakes, bus errors and asynchronous reset mid-transaction.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tvalid = 1'b0;
  logic        o_tready;
  logic [63:0] i_base_addr = '0;
  logic [63:0] i_offset = '0;
  logic [2:0]  i_width = '0;
  logic [63:0] i_data = '0;
  logic        o_awvalid;
  logic        i_awready = 1'b0;
  logic [63:0] o_awaddr;
  logic [2:0]  o_awprot;
  logic        o_wvalid;
  logic        i_wready = 1'b0;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        i_bvalid = 1'b0;
  logic        o_bready;
  logic [1:0]  i_bresp = '0;
  logic        o_done;
  logic        o_misaligned;
  logic        o_bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_tvalid     (i_tvalid),
    .o_tready     (o_tready),
    .i_base_addr  (i_base_addr),
    .i_offset     (i_offset),
    .i_width      (i_width),
    .i_data       (i_data),
    .o_awvalid    (o_awvalid),
    .i_awready    (i_awready),
    .o_awaddr     (o_awaddr),
    .o_awprot     (o_awprot),
    .o_wvalid     (o_wvalid),
    .i_wready     (i_wready),
    .o_wdata      (o_wdata),
    .o_wstrb      (o_wstrb),
    .i_bvalid     (i_bvalid),
    .o_bready     (o_bready),
    .i_bresp      (i_bresp),
    .o_done       (o_done),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [2:0] w, input logic [63:0] base,
                           input logic [63:0] off, input logic [63:0] data);
    i_tvalid    = 1'b1;
    i_width     = w;
    i_base_addr = base;
    i_offset    = off;
    i_data      = data;
  endtask

  // Store with AW/W ready immediately and B one cycle later; checks the full
  // T+1..T+4 timeline and the aligned bus fields.
  task automatic run_store(input string name, input logic [2:0] w, input logic [63:0] base,
                           input logic [63:0] off, input logic [63:0] data, input logic [1:0] bresp,
                           input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                           input logic [63:0] exp_data, input logic exp_err);
    check({name, ".tready_idle"}, 64'(o_tready), 64'd1);
    drive_req(w, base, off, data);
    i_awready = 1'b1;
    i_wready  = 1'b1;
    i_bvalid  = 1'b0;
    next_cycle();
    i_tvalid = 1'b0;
    check({name, ".t1_tready"}, 64'(o_tready), 64'd0);
    check({name, ".t1_awvalid"}, 64'(o_awvalid), 64'd1);
    check({name, ".t1_wvalid"}, 64'(o_wvalid), 64'd1);
    check({name, ".awaddr"}, o_awaddr, exp_addr);
    check({name, ".wstrb"}, 64'(o_wstrb), 64'(exp_strb));
    check({name, ".wdata"}, o_wdata, exp_data);
    check({name, ".awprot"}, 64'(o_awprot), 64'd0);
    i_bvalid = 1'b1;
    i_bresp  = bresp;
    next_cycle();
    check({name, ".t2_awvalid"}, 64'(o_awvalid), 64'd0);
    check({name, ".t2_wvalid"}, 64'(o_wvalid), 64'd0);
    check({name, ".t2_bready"}, 64'(o_bready), 64'd1);
    check({name, ".t2_done"}, 64'(o_done), 64'd0);
    next_cycle();
    i_bvalid  = 1'b0;
    i_awready = 1'b0;
    i_wready  = 1'b0;
    check({name, ".t3_done"}, 64'(o_done), 64'd1);
    check({name, ".t3_bus_err"}, 64'(o_bus_err), 64'(exp_err));
    check({name, ".t3_misaligned"}, 64'(o_misaligned), 64'd0);
    check({name, ".t3_bready"}, 64'(o_bready), 64'd0);
    next_cycle();
    check({name, ".t4_done"}, 64'(o_done), 64'd0);
    check({name, ".t4_bus_err"}, 64'(o_bus_err), 64'd0);
    check({name, ".t4_tready"}, 64'(o_tready), 64'd1);
    $display("[TB] %s addr=0x%0h strb=0x%0h data=0x%0h err=%0d", name, exp_addr, exp_strb, exp_data, exp_err);
  endtask

  task automatic run_fault(input string name, input logic [2:0] w, input logic [63:0] base,
                           input logic [63:0] off);
    drive_req(w, base, off, 64'h55);
    next_cycle();
    i_tvalid = 1'b0;
    check({name, ".t1_done"}, 64'(o_done), 64'd1);
    check({name, ".t1_misaligned"}, 64'(o_misaligned), 64'd1);
    check({name, ".t1_bus_err"}, 64'(o_bus_err), 64'd0);
    check({name, ".t1_awvalid"}, 64'(o_awvalid), 64'd0);
    check({name, ".t1_wvalid"}, 64'(o_wvalid), 64'd0);
    check({name, ".t1_tready"}, 64'(o_tready), 64'd0);
    next_cycle();
    check({name, ".t2_done"}, 64'(o_done), 64'd0);
    check({name, ".t2_misaligned"}, 64'(o_misaligned), 64'd0);
    check({name, ".t2_tready"}, 64'(o_tready), 64'd1);
    $display("[TB] %s fault width=%0d addr=0x%0h", name, w, base + off);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst.tready", 64'(o_tready), 64'd1);
    check("rst.awvalid", 64'(o_awvalid), 64'd0);
    check("rst.wvalid", 64'(o_wvalid), 64'd0);
    check("rst.bready", 64'(o_bready), 64'd0);
    check("rst.done", 64'(o_done), 64'd0);
    check("rst.awaddr", o_awaddr, 64'd0);
    check("rst.wdata", o_wdata, 64'd0);
    check("rst.wstrb", 64'(o_wstrb), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_store("sd", 3'b011, 64'h1000, 64'h8, 64'h1122334455667788, 2'b00,
              64'h1008, 8'hFF, 64'h1122334455667788, 1'b0);
    run_store("sb", 3'b000, 64'h2000, 64'h5, 64'h00000000000000AB, 2'b00,
              64'h2005, 8'h20, 64'h0000AB0000000000, 1'b0);
    run_store("sh", 3'b001, 64'h2000, 64'h2, 64'h000000000000BEEF, 2'b00,
              64'h2002, 8'h0C, 64'h00000000BEEF0000, 1'b0);
    // Negative offset wraps the sum: 0x2010 + (-8) = 0x2008
    run_store("sw_neg", 3'b010, 64'h2010, 64'hFFFFFFFFFFFFFFF8, 64'h00000000CAFEF00D, 2'b00,
              64'h2008, 8'h0F, 64'h00000000CAFEF00D, 1'b0);

    run_fault("sh_mis", 3'b001, 64'h3000, 64'h3);
    run_fault("sw_mis", 3'b010, 64'h3000, 64'h2);
    run_fault("sd_mis", 3'b011, 64'h3000, 64'h4);
    run_fault("f3_111", 3'b111, 64'h3000, 64'h0);

    // SW at 0x4004: W ready at T+1, AW ready only at T+4
    drive_req(3'b010, 64'h4000, 64'h4, 64'h00000000DEADBEEF);
    i_awready = 1'b0;
    i_wready  = 1'b1;
    next_cycle();
    i_tvalid = 1'b0;
    check("split.t1_awvalid", 64'(o_awvalid), 64'd1);
    check("split.t1_wvalid", 64'(o_wvalid), 64'd1);
    check("split.wstrb", 64'(o_wstrb), 64'hF0);
    check("split.wdata", o_wdata, 64'hDEADBEEF00000000);
    next_cycle();
    i_wready = 1'b0;
    check("split.t2_wvalid", 64'(o_wvalid), 64'd0);
    check("split.t2_awvalid", 64'(o_awvalid), 64'd1);
    check("split.t2_bready", 64'(o_bready), 64'd0);
    next_cycle();
    check("split.t3_awvalid", 64'(o_awvalid), 64'd1);
    check("split.t3_awaddr", o_awaddr, 64'h4004);
    check("split.t3_bready", 64'(o_bready), 64'd0);
    next_cycle();
    i_awready = 1'b1;
    check("split.t4_awvalid", 64'(o_awvalid), 64'd1);
    check("split.t4_awaddr", o_awaddr, 64'h4004);
    next_cycle();
    i_awready = 1'b0;
    check("split.t5_awvalid", 64'(o_awvalid), 64'd0);
    check("split.t5_bready", 64'(o_bready), 64'd1);
    i_bvalid = 1'b1;
    i_bresp  = 2'b00;
    next_cycle();
    i_bvalid = 1'b0;
    check("split.t6_done", 64'(o_done), 64'd1);
    check("split.t6_bus_err", 64'(o_bus_err), 64'd0);
    next_cycle();
    check("split.t7_tready", 64'(o_tready), 64'd1);
    $display("[TB] split sw addr=0x4004 aw late, w early");

    run_store("sd_slverr", 3'b011, 64'h5000, 64'h0, 64'h0102030405060708, 2'b10,
              64'h5000, 8'hFF, 64'h0102030405060708, 1'b1);
    run_store("sd_decerr", 3'b011, 64'h5008, 64'h0, 64'h0, 2'b11,
              64'h5008, 8'hFF, 64'h0, 1'b1);
    run_store("sd_okay", 3'b011, 64'h5010, 64'h0, 64'hA5A5A5A5A5A5A5A5, 2'b00,
              64'h5010, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 1'b0);

    // Asynchronous reset while in SEND
    drive_req(3'b011, 64'h6000, 64'h0, 64'hFFFF0000FFFF0000);
    i_awready = 1'b0;
    i_wready  = 1'b0;
    next_cycle();
    i_tvalid = 1'b0;
    check("arst.pre_awvalid", 64'(o_awvalid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst.awvalid", 64'(o_awvalid), 64'd0);
    check("arst.wvalid", 64'(o_wvalid), 64'd0);
    check("arst.awaddr", o_awaddr, 64'd0);
    check("arst.wdata", o_wdata, 64'd0);
    check("arst.wstrb", 64'(o_wstrb), 64'd0);
    check("arst.tready", 64'(o_tready), 64'd1);
    $display("[TB] async reset during SEND");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_store("post_rst", 3'b000, 64'h7000, 64'h7, 64'h00000000000000C3, 2'b00,
              64'h7007, 8'h80, 64'hC300000000000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
